// File: rtl/bar_scheduler.sv
// Double-buffered spectrum bar renderer: a writer fills the back height bank, banks swap at
// vertical blank start, and a two-stage pixel pipeline lights bars from the front bank.
module bar_scheduler #(
   parameter int BARS  = 32,
   parameter int BAR_W = 25,
   parameter int H_ACT = 800,
   parameter int V_ACT = 600
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic [10:0] i_xpos,
   input  logic [10:0] i_ypos,
   input  logic        i_disp_active,
   input  logic        i_wr_valid,
   output logic        o_wr_ready,
   input  logic [4:0]  i_wr_bin,
   input  logic [9:0]  i_wr_height,
   input  logic        i_wr_last,
   output logic        o_bar_on,
   output logic        o_active_out,
   output logic        o_swapped
);

   localparam int IDX_W = (BARS > 1) ? $clog2(BARS) : 1;
   localparam int SUB_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
   localparam logic [9:0] HMAX = 10'(V_ACT);
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(BAR_W - 1);

   typedef enum logic [1:0] {StFill, StPending, StSwap} state_e;

   state_e            r_state;
   state_e            w_state_d;
   logic              r_bank_sel;
   logic [9:0]        r_bank [2][BARS];
   logic              w_accept;
   logic              w_blank;
   logic              w_bin_ok;
   logic [9:0]        w_wr_h;

   logic [SUB_W-1:0]  r_sub;
   logic [10:0]       r_bin;
   logic              r_act1;
   logic [10:0]       r_y1;
   logic              r_act2;
   logic              r_bar_on;
   logic              w_bin_in;
   logic [9:0]        w_front_h;
   logic [10:0]       w_row;
   logic              w_on;

   assign o_wr_ready   = (r_state == StFill) & ~i_reset;
   assign o_swapped    = (r_state == StSwap) & ~i_reset;
   assign o_bar_on     = r_bar_on;
   assign o_active_out = r_act2;

   assign w_accept = i_wr_valid & o_wr_ready;
   assign w_blank  = (i_xpos == 11'd0) && (i_ypos == 11'(V_ACT));
   assign w_bin_ok = {27'd0, i_wr_bin} < 32'(BARS);
   assign w_wr_h   = (i_wr_height > HMAX) ? HMAX : i_wr_height;

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StFill:    if (w_accept && i_wr_last) w_state_d = StPending;
         StPending: if (w_blank) w_state_d = StSwap;
         StSwap:    w_state_d = StFill;
         default:   w_state_d = StFill;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= StFill;
         r_bank_sel <= 1'b0;
      end else begin
         r_state <= w_state_d;
         if (r_state == StSwap) r_bank_sel <= ~r_bank_sel;
      end
   end

   // Writer only ever touches the back bank, so display reads stay frame-coherent.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         for (int b = 0; b < BARS; b++) begin
            r_bank[0][b] <= '0;
            r_bank[1][b] <= '0;
         end
      end else if (w_accept && w_bin_ok) begin
         r_bank[~r_bank_sel][IDX_W'(i_wr_bin)] <= w_wr_h;
      end
   end

   // Stage 1: bar/sub-column counters replace an x / BAR_W divider.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_sub  <= '0;
         r_bin  <= '0;
         r_act1 <= 1'b0;
         r_y1   <= '0;
      end else begin
         r_act1 <= i_disp_active;
         r_y1   <= i_ypos;
         if (i_xpos == 11'd0) begin
            r_sub <= '0;
            r_bin <= '0;
         end else if (i_xpos < 11'(H_ACT)) begin
            if (r_sub == SUB_LAST) begin
               r_sub <= '0;
               r_bin <= r_bin + 11'd1;
            end else begin
               r_sub <= r_sub + SUB_W'(1);
            end
         end
      end
   end

   assign w_bin_in  = r_bin < 11'(BARS);
   assign w_front_h = w_bin_in ? r_bank[r_bank_sel][IDX_W'(r_bin)] : '0;
   // Wraps to a large value below the active area, which never compares lit.
   assign w_row     = 11'(V_ACT - 1) - r_y1;
   assign w_on      = r_act1 && w_bin_in && (r_sub != SUB_LAST) && (w_row < {1'b0, w_front_h});

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_act2   <= 1'b0;
         r_bar_on <= 1'b0;
      end else begin
         r_act2   <= r_act1;
         r_bar_on <= w_on;
      end
   end

endmodule

// File: tb/tb_bar_scheduler.sv
// Randomized bench for bar_scheduler; a bank-level model predicts swaps and every lit pixel.
module tb_bar_scheduler;

   localparam int BARS  = 30;
   localparam int BAR_W = 25;
   localparam int H_ACT = 800;
   localparam int V_ACT = 600;
   localparam int NPIX  = H_ACT + 4;

   logic        clk = 1'b0;
   logic        i_reset;
   logic [10:0] i_xpos, i_ypos;
   logic        i_disp_active, i_wr_valid, i_wr_last;
   logic [4:0]  i_wr_bin;
   logic [9:0]  i_wr_height;
   logic        o_wr_ready, o_bar_on, o_active_out, o_swapped;

   int total = 0;
   int bad   = 0;

   int m_front [BARS];
   int m_back  [BARS];
   bit m_pending;

   always #5 clk = ~clk;

   bar_scheduler #(
      .BARS  (BARS),
      .BAR_W (BAR_W),
      .H_ACT (H_ACT),
      .V_ACT (V_ACT)
   ) dut (
      .i_clock       (clk),
      .i_reset       (i_reset),
      .i_xpos        (i_xpos),
      .i_ypos        (i_ypos),
      .i_disp_active (i_disp_active),
      .i_wr_valid    (i_wr_valid),
      .o_wr_ready    (o_wr_ready),
      .i_wr_bin      (i_wr_bin),
      .i_wr_height   (i_wr_height),
      .i_wr_last     (i_wr_last),
      .o_bar_on      (o_bar_on),
      .o_active_out  (o_active_out),
      .o_swapped     (o_swapped)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int clamp(input int h);
      return (h > V_ACT) ? V_ACT : h;
   endfunction

   function automatic bit exp_on(input int x, input int y);
      int b;
      b = x / BAR_W;
      if (x >= H_ACT || y >= V_ACT || b >= BARS) return 1'b0;
      if (x % BAR_W == BAR_W - 1) return 1'b0;
      return (V_ACT - 1 - y) < m_front[b];
   endfunction

   task automatic model_clear();
      for (int b = 0; b < BARS; b++) begin
         m_front[b] = 0;
         m_back[b]  = 0;
      end
      m_pending = 1'b0;
   endtask

   task automatic wr_beat(input int bin, input int h, input bit last);
      i_xpos = 11'd7; i_ypos = 11'd0; i_disp_active = 1'b0;
      i_wr_valid = 1'b1; i_wr_bin = 5'(bin); i_wr_height = 10'(h); i_wr_last = last;
      total++;
      if (o_wr_ready !== 1'b1) begin
         bad++; $display("FAIL wr_ready_beat bin=%0d got=%b want=1", bin, o_wr_ready);
      end
      step();
      if (bin < BARS) m_back[bin] = clamp(h);
      if (last) m_pending = 1'b1;
      i_wr_valid = 1'b0; i_wr_last = 1'b0;
      if (last) begin
         total++;
         if (o_wr_ready !== 1'b0) begin
            bad++; $display("FAIL wr_ready_after_last got=%b want=0", o_wr_ready);
         end
      end
   endtask

   task automatic idle(input int n);
      bit sw = 1'b0;
      for (int i = 0; i < n; i++) begin
         i_xpos = 11'(1 + i % 700); i_ypos = 11'd10; i_disp_active = 1'b0;
         step();
         if (o_swapped === 1'b1) sw = 1'b1;
      end
      total++;
      if (sw !== 1'b0 || o_wr_ready !== !m_pending) begin
         bad++;
         $display("FAIL idle swapped=%b ready=%b want swapped=0 ready=%b", sw, o_wr_ready,
                  !m_pending);
      end
   endtask

   task automatic do_blank();
      bit want_sw;
      want_sw = m_pending;
      i_xpos = 11'd0; i_ypos = 11'(V_ACT); i_disp_active = 1'b0;
      step();
      total++;
      if (o_swapped !== want_sw || o_wr_ready !== !want_sw) begin
         bad++;
         $display("FAIL blank_pulse swapped=%b ready=%b want swapped=%b ready=%b",
                  o_swapped, o_wr_ready, want_sw, !want_sw);
      end
      i_xpos = 11'd1;
      step();
      if (m_pending) begin
         for (int b = 0; b < BARS; b++) begin
            int t;
            t = m_front[b]; m_front[b] = m_back[b]; m_back[b] = t;
         end
         m_pending = 1'b0;
      end
      total++;
      if (o_swapped !== 1'b0 || o_wr_ready !== 1'b1) begin
         bad++;
         $display("FAIL blank_after swapped=%b ready=%b want swapped=0 ready=1",
                  o_swapped, o_wr_ready);
      end
   endtask

   // Scans one active line; with wr set, random non-final beats hit the back bank meanwhile.
   task automatic check_line(input int y, input bit wr);
      logic [NPIX-1:0] e_on, o_on, e_act, o_act;
      int bin, h, first;
      e_on = '0; o_on = '0; e_act = '0; o_act = '0;
      for (int i = 0; i <= NPIX; i++) begin
         i_xpos = 11'(i); i_ypos = 11'(y); i_disp_active = (i < H_ACT);
         if (i < NPIX) begin
            e_on[i]  = exp_on(i, y);
            e_act[i] = (i < H_ACT);
         end
         i_wr_valid = 1'b0;
         if (wr && $urandom_range(0, 1) == 1) begin
            bin = $urandom_range(0, 31); h = $urandom_range(0, 1023);
            i_wr_valid = 1'b1; i_wr_bin = 5'(bin); i_wr_height = 10'(h); i_wr_last = 1'b0;
         end
         step();
         if (i_wr_valid && bin < BARS) m_back[bin] = clamp(h);
         if (i >= 1) begin
            o_on[i-1]  = o_bar_on;
            o_act[i-1] = o_active_out;
         end
      end
      i_wr_valid = 1'b0;
      total++;
      if (o_on !== e_on) begin
         first = -1;
         for (int i = NPIX - 1; i >= 0; i--) if (o_on[i] !== e_on[i]) first = i;
         bad++;
         $display("FAIL bar_on line=%0d first_x=%0d got=%b want=%b", y, first, o_on[first],
                  e_on[first]);
      end
      total++;
      if (o_act !== e_act) begin
         bad++; $display("FAIL active_out line=%0d got=%h want=%h", y, o_act, e_act);
      end
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         i_xpos = 11'($urandom_range(0, 799)); i_ypos = 11'($urandom_range(0, 599));
         i_disp_active = 1'b1;
         step();
      end
      total++;
      if ({o_wr_ready, o_bar_on, o_active_out, o_swapped} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_outputs got=%b want=0000",
                  {o_wr_ready, o_bar_on, o_active_out, o_swapped});
      end
      i_reset = 1'b0; i_disp_active = 1'b0; i_xpos = 11'd3;
      step();
      model_clear();
      total++;
      if (o_wr_ready !== 1'b1 || o_swapped !== 1'b0) begin
         bad++; $display("FAIL reset_release ready=%b swapped=%b want 1 0", o_wr_ready, o_swapped);
      end
   endtask

   task automatic test_fill_swap();
      for (int b = 0; b < 32; b++) wr_beat(b, 100, b == 31);
      idle(40);
      do_blank();
      check_line(0, 1'b0);
      check_line(499, 1'b0);
      check_line(500, 1'b0);
      check_line(599, 1'b0);
      check_line($urandom_range(1, 498), 1'b0);
   endtask

   task automatic test_clamp();
      wr_beat(3, 1023, 1'b1);
      idle(5);
      do_blank();
      check_line(0, 1'b0);
      check_line(300, 1'b0);
      check_line(599, 1'b0);
   endtask

   task automatic test_out_of_range();
      wr_beat(31, 50, 1'b1);
      idle(5);
      do_blank();
      check_line(560, 1'b0);
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < 40; k++) begin
            wr_beat($urandom_range(0, 31), ($urandom_range(0, 3) == 0) ? $urandom_range(600, 1023)
                    : $urandom_range(0, 599), 1'b0);
         end
         // Front must not see writes landing during these scans.
         check_line($urandom_range(0, 599), 1'b1);
         wr_beat($urandom_range(0, 31), $urandom_range(0, 1023), 1'b1);
         idle(3);
         do_blank();
         check_line($urandom_range(0, 599), 1'b0);
      end
   endtask

   task automatic test_last_on_blank();
      bit sw = 1'b0;
      i_xpos = 11'd0; i_ypos = 11'(V_ACT); i_disp_active = 1'b0;
      i_wr_valid = 1'b1; i_wr_bin = 5'd5; i_wr_height = 10'd200; i_wr_last = 1'b1;
      total++;
      if (o_wr_ready !== 1'b1) begin
         bad++; $display("FAIL last_on_blank_ready got=%b want=1", o_wr_ready);
      end
      step();
      m_back[5] = 200; m_pending = 1'b1;
      i_wr_valid = 1'b0; i_wr_last = 1'b0; i_xpos = 11'd1;
      for (int i = 0; i < 4; i++) begin
         if (o_swapped === 1'b1) sw = 1'b1;
         step();
      end
      total++;
      if (sw !== 1'b0 || o_wr_ready !== 1'b0) begin
         bad++;
         $display("FAIL last_on_blank_hold swapped=%b ready=%b want 0 0", sw, o_wr_ready);
      end
      idle(20);
      do_blank();
      check_line(450, 1'b0);
   endtask

   task automatic test_reset_pending();
      wr_beat(2, 300, 1'b1);
      idle(5);
      i_reset = 1'b1;
      step();
      total++;
      if (o_bar_on !== 1'b0 || o_wr_ready !== 1'b0 || o_swapped !== 1'b0) begin
         bad++;
         $display("FAIL reset_pending bar_on=%b ready=%b swapped=%b want 000", o_bar_on,
                  o_wr_ready, o_swapped);
      end
      i_reset = 1'b0;
      step();
      model_clear();
      total++;
      if (o_wr_ready !== 1'b1) begin
         bad++; $display("FAIL reset_pending_ready got=%b want=1", o_wr_ready);
      end
      do_blank();
      check_line(599, 1'b0);
      check_line(100, 1'b0);
   endtask

   initial begin
      i_reset = 1'b1; i_xpos = '0; i_ypos = '0; i_disp_active = 1'b0;
      i_wr_valid = 1'b0; i_wr_bin = '0; i_wr_height = '0; i_wr_last = 1'b0;
      model_clear();
      test_reset();
      test_fill_swap();
      test_clamp();
      test_out_of_range();
      test_random_frames();
      test_last_on_blank();
      test_reset_pending();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
